// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W   = 5;   // register address width (32 registers)
  localparam int DATA_W   = 32;  // register data width
  localparam int ZERO_REG = 0;   // hard-wired zero register, never written
  localparam int CNT_W    = 16;  // collision counter width

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: grants the first set request
// found when searching ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  // Rotating search; the first hit wins and blocks all later candidates.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (int'(ptr) + k) % N;
      if (!any_gnt && req[i]) begin
        any_gnt = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ requesters. The winner's address/data are staged for one cycle and
// then drive the write strobe and per-register one-hot write enables.
// Writes to the zero register complete their handshake but are suppressed.
// Optional feature: define REGFILE_ARB_COLLISION_CNT_EN to add a saturating
// count of cycles in which two or more requesters competed.
//
// Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i]
// are both high at the rising clock edge. req_valid must not depend on
// req_ready, and req_addr/req_data stay stable while valid is high and ready
// is low. req_ready is combinational and at most one-hot.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W  = regfile_arb_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wr_enable,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [(2**ADDR_W)-1:0]      wr_onehot
`ifdef REGFILE_ARB_COLLISION_CNT_EN
  ,
  output logic [regfile_arb_pkg::CNT_W-1:0] collision_cnt
`endif
);

  import regfile_arb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wr_enable_q, wr_enable_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_gnt (pick_any)
  );

  // Grants are blocked while hold or reset is high.
  always_comb begin
    req_ready = (hold || reset) ? '0 : pick_gnt;
    handshake = pick_any && !hold && !reset;
  end

  // Select the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state for the output stage and the round-robin pointer.
  always_comb begin
    wr_enable_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (handshake) begin
      wr_addr_d   = sel_addr;
      wr_data_d   = sel_data;
      wr_enable_d = (sel_addr != ADDR_W'(ZERO_REG));
      rr_ptr_d    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end
  end

  // Output stage and pointer; reset discards any staged write at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      wr_enable_q <= wr_enable_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Per-register write enables decoded from the staged write.
  always_comb begin
    wr_onehot = '0;
    if (wr_enable_q) wr_onehot[wr_addr_q] = 1'b1;
  end

  assign wr_enable = wr_enable_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

`ifdef REGFILE_ARB_COLLISION_CNT_EN
  logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  // Count unheld cycles with two or more requests, saturating at all-ones.
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (!hold && ($countones(req_valid) >= 2) && (coll_cnt_q != '1))
      coll_cnt_d = coll_cnt_q + CNT_W'(1);
  end

  // Collision counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) coll_cnt_q <= '0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign collision_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (NUM_REQ = 2).
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      reset;
  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_enable;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [(2**ADDR_W)-1:0]    wr_onehot;
`ifdef REGFILE_ARB_COLLISION_CNT_EN
  logic [15:0]               collision_cnt;
`endif

  int n_vec;
  int n_err;
  logic [ADDR_W-1:0] exp_q[$];

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_onehot (wr_onehot)
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    ,
    .collision_cnt (collision_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    hold  = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_valid = 2'b11;
    #3;
    n_vec++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    step();
    n_vec++;
    if (wr_enable !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || wr_onehot !== 32'd0) begin
      n_err++; $display("FAIL reset_outputs: en=%b addr=%0d data=%h oh=%h want 0/0/0/0",
                        wr_enable, wr_addr, wr_data, wr_onehot);
    end
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    n_vec++;
    if (collision_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", collision_cnt);
    end
`endif
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready: got %b want 01", req_ready);
    end
    step();
    idle();
    n_vec++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd5 || wr_onehot !== 32'h20 || wr_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_write: en=%b addr=%0d oh=%h data=%h want 1/5/20/deadbeef",
                        wr_enable, wr_addr, wr_onehot, wr_data);
    end
    step();
    n_vec++;
    if (wr_enable !== 1'b0 || wr_onehot !== 32'd0 || wr_addr !== 5'd5) begin
      n_err++; $display("FAIL single_drop: en=%b oh=%h addr=%0d want 0/0/5", wr_enable, wr_onehot, wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        exp_gnt;
    logic [ADDR_W-1:0] exp_a;
    apply_reset();
    set_req(0, 1'b1, 5'd3, 32'hAAAA0003);
    set_req(1, 1'b1, 5'd7, 32'hBBBB0007);
    for (int c = 0; c < 4; c++) begin
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back((c % 2 == 0) ? 5'd3 : 5'd7);
      #1;
      n_vec++;
      if (req_ready !== exp_gnt) begin
        n_err++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, req_ready, exp_gnt);
      end
      step();
      exp_a = exp_q.pop_front();
      n_vec++;
      if (wr_enable !== 1'b1 || wr_addr !== exp_a) begin
        n_err++; $display("FAIL b2b_write[%0d]: en=%b addr=%0d want 1/%0d", c, wr_enable, wr_addr, exp_a);
      end
    end
    idle();
    n_vec++;
    if (wr_data !== 32'hBBBB0007 || wr_onehot !== 32'h80) begin
      n_err++; $display("FAIL b2b_last: data=%h oh=%h want bbbb0007/80", wr_data, wr_onehot);
    end
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    n_vec++;
    if (collision_cnt !== 16'd4) begin
      n_err++; $display("FAIL b2b_cnt: got %0d want 4", collision_cnt);
    end
`endif
    step();
  endtask

  task automatic test_zero_reg();
    // Requester 0 writes first so the pointer sits at 1.
    set_req(0, 1'b1, 5'd2, 32'h00000022);
    step();
    idle();
    set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL zero_ready: got %b want 10", req_ready);
    end
    step();
    idle();
    n_vec++;
    if (wr_enable !== 1'b0 || wr_onehot !== 32'd0 || wr_addr !== 5'd0 || wr_data !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL zero_suppress: en=%b oh=%h addr=%0d data=%h want 0/0/0/ffffffff",
                        wr_enable, wr_onehot, wr_addr, wr_data);
    end
    // Pointer advanced past 1, so requester 0 wins next.
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd6, 32'h66);
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL zero_ptr_adv: got %b want 01", req_ready);
    end
    idle();
    step();
  endtask

  task automatic test_hold();
    set_req(0, 1'b1, 5'd9, 32'h99);
    step();
    hold = 1'b1;
    set_req(0, 1'b1, 5'd10, 32'h1010);
    set_req(1, 1'b1, 5'd11, 32'h1111);
    #1;
    n_vec++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd9) begin
      n_err++; $display("FAIL hold_staged: en=%b addr=%0d want 1/9", wr_enable, wr_addr);
    end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL hold_ready[%0d]: got %b want 00", c, req_ready);
      end
      step();
      n_vec++;
      if (wr_enable !== 1'b0 || wr_addr !== 5'd9) begin
        n_err++; $display("FAIL hold_write[%0d]: en=%b addr=%0d want 0/9", c, wr_enable, wr_addr);
      end
    end
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    n_vec++;
    if (collision_cnt !== 16'd4) begin
      n_err++; $display("FAIL hold_cnt: got %0d want 4", collision_cnt);
    end
`endif
    hold = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL hold_release: got %b want 10", req_ready);
    end
    step();
    idle();
    n_vec++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd11 || wr_data !== 32'h1111) begin
      n_err++; $display("FAIL hold_after: en=%b addr=%0d data=%h want 1/11/1111", wr_enable, wr_addr, wr_data);
    end
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    n_vec++;
    if (collision_cnt !== 16'd5) begin
      n_err++; $display("FAIL hold_cnt_after: got %0d want 5", collision_cnt);
    end
`endif
    step();
  endtask

  task automatic test_reset_midop();
    set_req(1, 1'b1, 5'd12, 32'hC0C0);
    step();
    idle();
    n_vec++;
    if (wr_enable !== 1'b1 || wr_addr !== 5'd12) begin
      n_err++; $display("FAIL midop_staged: en=%b addr=%0d want 1/12", wr_enable, wr_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (wr_enable !== 1'b0 || wr_onehot !== 32'd0 || wr_addr !== 5'd0) begin
      n_err++; $display("FAIL midop_async: en=%b oh=%h addr=%0d want 0/0/0", wr_enable, wr_onehot, wr_addr);
    end
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL midop_ptr: got %b want 01", req_ready);
    end
    idle();
    step();
  endtask

`ifdef REGFILE_ARB_COLLISION_CNT_EN
  task automatic test_saturation();
    apply_reset();
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    for (int c = 0; c < 70000; c++) step();
    idle();
    n_vec++;
    if (collision_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL cnt_saturate: got %h want ffff", collision_cnt);
    end
    step();
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_zero_reg();
    test_hold();
    test_reset_midop();
`ifdef REGFILE_ARB_COLLISION_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 32-bit register file (`register32` array, entry 0 built from `register32zero`) among several write requesters, e.g. ALU writeback and load writeback. Each cycle it picks at most one valid requester round-robin, registers the winning address and data, and drives the file's per-register write enables one cycle later. Writes to register 0 complete their handshake but are suppressed, so the zero register is never written.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `clk`  in  1  single clock, positive edge.
- `reset`  in  1  asynchronous, active-high reset.
- `hold`  in  1  when high, no grants are issued.
- `req_valid`  in  NUM_REQ  requester i has a write pending.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*DATA_W  packed write data, same packing.
- `req_ready`  out  NUM_REQ  one-hot grant; handshake = valid & ready.
- `wr_enable`  out  1  register-file write strobe.
- `wr_addr`  out  ADDR_W  register-file write address.
- `wr_data`  out  DATA_W  register-file write data.
- `wr_onehot`  out  2**ADDR_W  decoded per-register wrenable = wr_enable ? (1 << wr_addr) : 0.
- `collision_cnt`  out  16  present only with REGFILE_ARB_COLLISION_CNT_EN.

## Operation
- State: round-robin pointer `rr_ptr` (0..NUM_REQ-1), output stage {wr_enable, wr_addr, wr_data}.
- Grant: if !hold, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. `req_ready` is combinational from req_valid, hold and rr_ptr, and is at most one-hot.
- Requesters must not make req_valid depend on req_ready. Address and data are held stable while valid and not ready.
- On handshake with requester g: next cycle wr_addr = req_addr[g] and wr_data = req_data[g]. wr_enable = 1 unless req_addr[g] == 0. rr_ptr <= (g+1) mod NUM_REQ.
- No handshake, including when hold is high: wr_enable <= 0. wr_addr, wr_data and rr_ptr keep their values.
- The register file always accepts writes, so there is no backpressure from the output side.
- Address 0 write: the handshake completes and the pointer advances, but wr_enable stays 0 and wr_onehot stays all-zero.

## Timing
- Reset (async assert, released on clk edge): wr_enable=0, wr_addr=0, wr_data=0, rr_ptr=0, collision_cnt=0. req_ready=0 while reset is high.
- Latency is 1 cycle from handshake edge to wr_enable high. The register file captures the data on the following edge, so a write is visible to reads 2 edges after the handshake.
- Throughput is one write per cycle, sustained.
- Reset asserted mid-operation: an in-flight staged write is discarded, with wr_enable forced to 0 immediately.
- hold rising in the same cycle as valid: no grant that cycle. Hold has no effect on a write already staged.

## Configuration
- `REGFILE_ARB_COLLISION_CNT_EN` defined: adds the `collision_cnt` port and a 16-bit counter.
  - Increments on each cycle with !hold and two or more req_valid bits set.
  - Saturates at 16'hFFFF and is cleared by reset.
- Undefined: port and counter are absent. Arbitration behaviour is identical.

## Structure
- Package `regfile_arb_pkg`: `ADDR_W`, `DATA_W`, `ZERO_REG` (= 0), `CNT_W` (= 16).
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-grant flag.
- The top level holds the pointer, the output stage, the one-hot decode and the optional counter.

## Test plan
- After reset, requester 0 writes addr 5, data 32'hDEADBEEF -> next cycle wr_enable=1, wr_addr=5, wr_onehot=32'h20, wr_data=32'hDEADBEEF. The following cycle wr_enable=0.
- Both requesters valid for 4 cycles (NUM_REQ=2, rr_ptr=0) -> grants alternate 0,1,0,1. With the macro defined, collision_cnt=4.
- Requester 1 writes addr 0, data 32'hFFFFFFFF -> req_ready[1]=1 and the pointer advances, but wr_enable=0 and wr_onehot=0.
- hold=1 with both requesters valid for 3 cycles -> req_ready=0 and wr_enable=0 throughout, collision_cnt unchanged. After hold drops, requester rr_ptr is granted first.
- reset asserted in the cycle after a handshake -> wr_enable drops to 0 without waiting for a clock edge. After reset releases, rr_ptr=0.
- Counter saturation with the macro defined: force 70000 collision cycles -> collision_cnt=16'hFFFF.
